// File: rtl/flash_reader_pkg.sv
// Shared types and sizing for the flash sample reader and its helpers.
// Combinational helper only; no latency, no flow control.
package flash_reader_pkg;

    localparam int ADDR_W   = 23;
    localparam int SAMPLE_W = 16;
    localparam int DATA_W   = 2 * SAMPLE_W;
    localparam int TIMEOUT  = 255;

    localparam int HALF_LO = 0;
    localparam int HALF_HI = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    // sel = HALF_HI picks the upper sample, HALF_LO the lower one.
    function automatic logic [SAMPLE_W-1:0] pick_half(
        input logic [DATA_W-1:0] word,
        input logic              sel
    );
        return (sel == 1'(HALF_HI)) ? word[DATA_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-only link between the sample reader (master) and flash controller (slave).
// Wires only; no latency. Backpressure is the slave's flash_waitrequest.
interface flash_sample_reader_if;
    import flash_reader_pkg::*;

    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic              flash_waitrequest;
    logic              flash_readdatavalid;
    logic [DATA_W-1:0] flash_readdata;

    modport master (
        output flash_read,
        output flash_address,
        input  flash_waitrequest,
        input  flash_readdatavalid,
        input  flash_readdata
    );

    modport slave (
        input  flash_read,
        input  flash_address,
        output flash_waitrequest,
        output flash_readdatavalid,
        output flash_readdata
    );

endinterface

// File: rtl/timeout_counter.sv
// Cycle watchdog for an outstanding bus transaction; expired flags the MAX-th enabled cycle.
// Combinational expired output off a registered count; no backpressure.
module timeout_counter #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] r_count;

    // Saturates so a caller that ignores expired never sees a wrap.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != W'(MAX))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == W'(MAX - 1));

endmodule

// File: rtl/flash_sample_reader.sv
// Fetches one 32-bit flash word per two sample ticks and plays it out as two 16-bit samples.
// sample_valid one cycle after readdatavalid; stalls on flash_waitrequest, drops ticks that land mid-fetch.
module flash_sample_reader
    import flash_reader_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_tick,
    input  logic                       read_en,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       backward,
    flash_sample_reader_if.master      avm,
    output logic [SAMPLE_W-1:0]        sample_out,
    output logic                       sample_valid,
    output logic                       addr_advance,
    output logic                       underrun,
    output logic                       timeout_err
);

    state_t              r_state;
    logic                r_flash_read;
    logic [ADDR_W-1:0]   r_flash_address;
    logic                r_dir;
    logic [DATA_W-1:0]   r_word;
    logic [SAMPLE_W-1:0] r_sample_out;
    logic                r_sample_valid;
    logic                r_addr_advance;
    logic                r_underrun;
    logic                r_timeout_err;

    logic w_accept;
    logic w_expired;

    assign w_accept = (r_state == REQ) && !avm.flash_waitrequest;

    timeout_counter #(.MAX(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_accept),
        .enable  (r_state == WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_flash_read    <= 1'b0;
            r_flash_address <= '0;
            r_dir           <= 1'b0;
            r_word          <= '0;
            r_sample_out    <= '0;
            r_sample_valid  <= 1'b0;
            r_addr_advance  <= 1'b0;
            r_underrun      <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_addr_advance <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_tick && read_en) begin
                        r_flash_address <= addr;
                        r_dir           <= backward;
                        r_flash_read    <= 1'b1;
                        r_state         <= REQ;
                    end
                end
                REQ: begin
                    if (sample_tick) r_underrun <= 1'b1;
                    if (w_accept) begin
                        r_flash_read <= 1'b0;
                        r_state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (sample_tick) r_underrun <= 1'b1;
                    // Data is always taken so the slave transaction completes even when paused.
                    if (avm.flash_readdatavalid) begin
                        r_word <= avm.flash_readdata;
                        if (read_en) begin
                            r_sample_out   <= pick_half(avm.flash_readdata, r_dir);
                            r_sample_valid <= 1'b1;
                            r_state        <= HOLD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_expired) begin
                        r_sample_out   <= '0;
                        r_timeout_err  <= 1'b1;
                        r_addr_advance <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                HOLD: begin
                    if (sample_tick && read_en) begin
                        r_sample_out   <= pick_half(r_word, ~r_dir);
                        r_sample_valid <= 1'b1;
                        r_addr_advance <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign avm.flash_read    = r_flash_read;
    assign avm.flash_address = r_flash_address;
    assign sample_out        = r_sample_out;
    assign sample_valid      = r_sample_valid;
    assign addr_advance      = r_addr_advance;
    assign underrun          = r_underrun;
    assign timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed plus randomized bench for flash_sample_reader with a word-level playback model.
module tb_flash_sample_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_tick;
    logic        read_en;
    logic [22:0] addr;
    logic        backward;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        addr_advance;
    logic        underrun;
    logic        timeout_err;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    // Model state: last sample heard by the listener and the sticky flags.
    logic [15:0] exp_so;
    bit          exp_underrun;
    bit          exp_to;

    flash_sample_reader_if bus ();

    flash_sample_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_tick  (sample_tick),
        .read_en      (read_en),
        .addr         (addr),
        .backward     (backward),
        .avm          (bus.master),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .addr_advance (addr_advance),
        .underrun     (underrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_read"}, bus.flash_read, 0);
        chk({tag, "_addr"}, bus.flash_address, 0);
        chk({tag, "_so"}, sample_out, 0);
        chk({tag, "_sv"}, sample_valid, 0);
        chk({tag, "_adv"}, addr_advance, 0);
        chk({tag, "_urun"}, underrun, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
    endtask

    // One whole word: request, w stalled edges, data lat cycles after accept, optional pause in HOLD.
    task automatic fetch(input logic [22:0] a, input bit dir, input logic [31:0] data,
                         input int w, input int lat, input int pause, input bit tick_in_req);
        logic [15:0] first, second;
        first  = dir ? data[31:16] : data[15:0];
        second = dir ? data[15:0]  : data[31:16];

        read_en = 1'b1; addr = a; backward = dir; sample_tick = 1'b1;
        bus.flash_waitrequest = (w > 0);
        cyc();
        sample_tick = 1'b0;
        addr = 23'($urandom); backward = ~dir;
        chk("req_read", bus.flash_read, 1);
        chk("req_addr", bus.flash_address, 32'(a));

        if (tick_in_req) sample_tick = 1'b1;
        for (int i = 0; i < w; i++) begin
            cyc();
            sample_tick = 1'b0;
            chk("stall_read", bus.flash_read, 1);
            chk("stall_addr", bus.flash_address, 32'(a));
        end
        if (tick_in_req) exp_underrun = 1'b1;
        bus.flash_waitrequest = 1'b0;
        cyc();
        chk("accept_drop", bus.flash_read, 0);

        for (int i = 1; i < lat; i++) begin
            cyc();
            chk("wait_no_sv", sample_valid, 0);
        end
        bus.flash_readdatavalid = 1'b1;
        bus.flash_readdata = data;
        cyc();
        bus.flash_readdatavalid = 1'b0;
        bus.flash_readdata = $urandom;
        chk("first_sv", sample_valid, 1);
        chk("first_so", sample_out, 32'(first));
        chk("first_adv", addr_advance, 0);
        exp_so = first;

        if (pause > 0) begin
            read_en = 1'b0;
            for (int p = 0; p < pause; p++) begin
                sample_tick = 1'b1;
                cyc();
                sample_tick = 1'b0;
                chk("pause_sv", sample_valid, 0);
                chk("pause_adv", addr_advance, 0);
                chk("pause_so", sample_out, 32'(exp_so));
                cyc();
            end
            read_en = 1'b1;
        end else begin
            cyc();
            chk("hold_sv", sample_valid, 0);
            chk("hold_so", sample_out, 32'(exp_so));
        end

        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("second_sv", sample_valid, 1);
        chk("second_adv", addr_advance, 1);
        chk("second_so", sample_out, 32'(second));
        exp_so = second;
        cyc();
        chk("after_sv", sample_valid, 0);
        chk("after_adv", addr_advance, 0);
        chk("urun_flag", underrun, 32'(exp_underrun));
        chk("tmo_flag", timeout_err, 32'(exp_to));
    endtask

    initial begin
        int k;
        logic [31:0] d;

        reset_n = 1'b0; sample_tick = 1'b0; read_en = 1'b0; addr = '0; backward = 1'b0;
        bus.flash_waitrequest = 1'b0;
        bus.flash_readdatavalid = 1'b0;
        bus.flash_readdata = '0;
        exp_so = '0; exp_underrun = 1'b0; exp_to = 1'b0;
        cyc(); cyc();
        chk_all_zero("reset");
        reset_n = 1'b1;
        cyc();

        // A tick without read_en must not start a fetch.
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("idle_no_read", bus.flash_read, 0);

        fetch(23'h000010, 1'b0, 32'hBEEF_1234, 2, 3, 0, 1'b0);
        fetch(23'h000011, 1'b1, 32'hBEEF_1234, 2, 3, 0, 1'b0);
        fetch(23'h000012, 1'b0, 32'hBEEF_1234, 1, 2, 3, 1'b0);

        for (int n = 0; n < 20; n++) begin
            fetch(23'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3),
                  $urandom_range(1, 5), $urandom_range(0, 2), 1'b0);
        end

        // read_en falls while waiting: data is consumed silently, block returns to IDLE.
        read_en = 1'b1; addr = 23'h55; sample_tick = 1'b1; bus.flash_waitrequest = 1'b0;
        cyc();
        sample_tick = 1'b0;
        cyc();
        read_en = 1'b0;
        cyc();
        bus.flash_readdatavalid = 1'b1; bus.flash_readdata = 32'hCAFE_F00D;
        cyc();
        bus.flash_readdatavalid = 1'b0;
        chk("abort_sv", sample_valid, 0);
        chk("abort_adv", addr_advance, 0);
        chk("abort_so", sample_out, 32'(exp_so));
        fetch(23'h56, 1'b0, 32'h0BAD_5EED, 0, 1, 0, 1'b0);

        // Timeout: data never arrives.
        read_en = 1'b1; addr = 23'h77; sample_tick = 1'b1; bus.flash_waitrequest = 1'b0;
        cyc();
        sample_tick = 1'b0;
        cyc();
        chk("tmo_accept", bus.flash_read, 0);
        k = 0;
        while (k < 400) begin
            cyc();
            k++;
            if (addr_advance === 1'b1) break;
        end
        chk("tmo_cycles", k, 255);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_so", sample_out, 0);
        chk("tmo_sv", sample_valid, 0);
        exp_to = 1'b1; exp_so = '0;
        cyc();
        chk("tmo_adv_pulse", addr_advance, 0);
        chk("tmo_idle_read", bus.flash_read, 0);

        // Underrun: a second tick lands while the request is stalled.
        fetch(23'h000123, 1'b0, 32'hA5A5_3C3C, 3, 2, 0, 1'b1);
        fetch(23'h000124, 1'b1, $urandom, 1, 2, 0, 1'b0);

        // Reset mid-request, then a late readdatavalid must be ignored.
        read_en = 1'b1; addr = 23'h0ABCDE; sample_tick = 1'b1; bus.flash_waitrequest = 1'b1;
        cyc();
        sample_tick = 1'b0;
        chk("rst_req_read", bus.flash_read, 1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk_all_zero("midrst");
        d = $urandom;
        bus.flash_readdatavalid = 1'b1; bus.flash_readdata = d;
        cyc();
        bus.flash_readdatavalid = 1'b0;
        chk("late_rdv_sv", sample_valid, 0);
        cyc();
        chk("late_rdv_sv2", sample_valid, 0);
        chk("late_rdv_so", sample_out, 0);
        chk("late_rdv_read", bus.flash_read, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/flash_sample_reader.md
Name: flash_sample_reader

Overview:
Consumer side of the playback address/read interface. It takes the word address and read-enable produced by the keyboard-controlled playback FSM and performs the Avalon-MM read handshake to the 32-bit flash controller. Each fetched word is split into two 16-bit audio samples, which are presented to the audio output path on consecutive sample ticks. After the second sample it pulses `addr_advance`, so the address generator steps exactly once per consumed word.

Parameters:
- ADDR_W, 23, width of the flash word address.
- DATA_W, 32, flash read data width; fixed at 2 × SAMPLE_W.
- SAMPLE_W, 16, width of one audio sample.
- TIMEOUT, 255, maximum cycles to wait for `flash_readdatavalid` before aborting.

Ports:
- clk, in, 1: single system clock; all logic on rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- sample_tick, in, 1: one-cycle strobe at the audio sample rate.
- read_en, in, 1: playback active (the `read` output of the address FSM).
- addr, in, ADDR_W: current word address from the address FSM.
- backward, in, 1: 1 = reverse playback; selects the half-word order.
- flash_read, out, 1: Avalon read request.
- flash_address, out, ADDR_W: Avalon address.
- flash_waitrequest, in, 1: Avalon stall.
- flash_readdatavalid, in, 1: Avalon read data valid.
- flash_readdata, in, DATA_W: Avalon read data.
- sample_out, out, SAMPLE_W: current audio sample; held between updates.
- sample_valid, out, 1: one-cycle pulse when `sample_out` updates.
- addr_advance, out, 1: one-cycle pulse asking the address FSM to step.
- underrun, out, 1: sticky flag; a sample tick arrived while a fetch was outstanding.
- timeout_err, out, 1: sticky flag; a read timed out.

Behaviour:
- Reset (reset_n = 0 at a clk edge): state := IDLE. All outputs go to 0: `flash_read`, `flash_address`, `sample_out`, `sample_valid`, `addr_advance`, `underrun`, `timeout_err`. The timeout counter is cleared.
- Reset mid-transaction: return to IDLE and drop `flash_read` on that edge. Any later `readdatavalid` arriving while in IDLE is ignored.
- IDLE:
  - Leave only on `sample_tick && read_en`.
  - On that edge, latch `addr` into `flash_address` and `backward` into `dir_q`, then go to REQ.
- REQ:
  - `flash_read` = 1 and `flash_address` is held stable.
  - Stay while `flash_waitrequest` = 1.
  - When `flash_waitrequest` = 0, drop `flash_read` on the next edge, clear the timeout counter and go to WAIT.
  - Exactly one request is accepted per fetch.
- WAIT:
  - Count cycles while waiting for data.
  - On `flash_readdatavalid`, capture `flash_readdata` into `word_q`. If `read_en` is still 1, emit the first half and go to HOLD. If `read_en` is 0, go to IDLE with no output.
  - First half is [15:0] when `dir_q` = 0, and [31:16] when `dir_q` = 1.
  - Emitting a half means: `sample_out` := the half and `sample_valid` = 1 for one cycle.
  - When the counter reaches TIMEOUT with no data: `sample_out` := 0, `timeout_err` := 1, `addr_advance` pulse, go to IDLE.
  - Latency from the accept edge to `sample_valid` is one cycle after `readdatavalid`.
- HOLD:
  - Wait for the next `sample_tick`. On it, emit the other half, pulse `addr_advance` in the same cycle, and go to IDLE.
  - If `read_en` = 0 (paused), stay in HOLD with `sample_out` held. Resuming emits the second half on the next tick.
- `underrun`: set when `sample_tick` = 1 in REQ or WAIT. That tick is dropped, not queued.
- `sample_tick` in HOLD or IDLE coinciding with state entry: only ticks seen in the state itself count.
- `read_en` falling during REQ or WAIT: the Avalon transaction is always completed (never abandoned), then the block returns to IDLE.
- `sample_out` is never cleared except by reset or timeout. Pausing therefore holds the last sample.
- No arithmetic on `addr`; address stepping, wrap-around and direction stepping belong to the address FSM.

Decomposition:
- Package `flash_reader_pkg`:
  - state enum {IDLE, REQ, WAIT, HOLD}, 2 bits.
  - constants ADDR_W, DATA_W, SAMPLE_W, TIMEOUT.
  - localparam HALF_LO = 0, HALF_HI = 1.
- Sub-module `timeout_counter`:
  - Inputs: clear and enable. Output: `expired` at TIMEOUT.
  - Instantiated once in WAIT; reusable for other Avalon masters.
- Everything else stays in a single FSM module.

Test Plan:
1. Forward fetch: `read_en` = 1, `backward` = 0, `addr` = 23'h000010, tick; slave `waitrequest` high 2 cycles, then data 32'hBEEF_1234 3 cycles later.
   -> `flash_address` = 23'h10; `sample_out` = 16'h1234 with `sample_valid`; at the next tick `sample_out` = 16'hBEEF with `sample_valid` and `addr_advance` together.
2. Backward fetch: same data, `backward` = 1.
   -> first `sample_out` = 16'hBEEF, second = 16'h1234.
3. Pause in HOLD: drop `read_en` after the first half, send 3 ticks, then restore `read_en`.
   -> `sample_out` holds 16'h1234 with no pulses; the next tick gives 16'hBEEF plus `addr_advance`.
4. Timeout: slave never asserts `readdatavalid`.
   -> 255 cycles after accept: `timeout_err` = 1, `sample_out` = 0, one `addr_advance` pulse, state IDLE.
5. Underrun: hold `waitrequest` high across a second `sample_tick`.
   -> `underrun` = 1 and stays set; the fetch still completes with correct data.
6. Reset mid-REQ: assert `reset_n` = 0 for one edge while `flash_read` = 1.
   -> next cycle `flash_read` = 0 and all outputs = 0; a late `readdatavalid` produces no `sample_valid`.
